// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: shared field slicing, classification and constants for the floating ALU
package fp_alu_pkg;
  localparam int FPW = 64;
  typedef logic [FPW-1:0] fpw_t;
  localparam logic FUNCT_MIN = 1'b0;
  localparam logic FUNCT_MAX = 1'b1;
  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic sign;
  } fp_class_t;
  function automatic fpw_t fp_ones(int n);
    return (fpw_t'(1) << n) - fpw_t'(1);
  endfunction
  function automatic fpw_t fp_man(fpw_t x, int man_w);
    return x & fp_ones(man_w);
  endfunction
  function automatic fpw_t fp_exp(fpw_t x, int exp_w, int man_w);
    return (x >> man_w) & fp_ones(exp_w);
  endfunction
  function automatic logic fp_sign(fpw_t x, int exp_w, int man_w);
    fpw_t s = x >> (exp_w + man_w);
    return s[0];
  endfunction
  function automatic fpw_t fp_canon_nan(int exp_w, int man_w);
    return (fp_ones(exp_w) << man_w) | (fpw_t'(1) << (man_w - 1));
  endfunction
  function automatic fp_class_t fp_classify(fpw_t x, int exp_w, int man_w);
    fpw_t m = fp_man(x, man_w);
    fpw_t q = m >> (man_w - 1);
    fp_class_t c;
    c.sign    = fp_sign(x, exp_w, man_w);
    c.is_nan  = (fp_exp(x, exp_w, man_w) == fp_ones(exp_w)) && (m != '0);
    c.is_snan = c.is_nan & ~q[0];
    return c;
  endfunction
endpackage

// File: rtl/fp_cmp_core.sv
// fp_cmp_core: combinational total-order compare and min/max select with NaN handling
module fp_cmp_core
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = 1 + EXP_W + MAN_W
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  fp_class_t       a_cls_i,
  input  fp_class_t       b_cls_i,
  input  logic            funct_i,
  output logic [XLEN-1:0] res_o,
  output logic            nv_o
);
  logic lt;
  // Sign decides first (-0 < +0); magnitudes compare as integers, reversed when negative
  always_comb begin
    lt = (a_cls_i.sign != b_cls_i.sign) ? a_cls_i.sign :
         a_cls_i.sign ? (a_i[XLEN-2:0] > b_i[XLEN-2:0]) : (a_i[XLEN-2:0] < b_i[XLEN-2:0]);
    res_o = (a_cls_i.is_nan & b_cls_i.is_nan) ? XLEN'(fp_canon_nan(EXP_W, MAN_W)) :
            a_cls_i.is_nan ? b_i :
            b_cls_i.is_nan ? a_i :
            (lt ^ (funct_i == FUNCT_MAX)) ? a_i : b_i;
    nv_o = a_cls_i.is_snan | b_cls_i.is_snan;
  end
endmodule

// File: rtl/fp_minmax_pipe.sv
// fp_minmax_pipe: two-stage pipelined FP min/max with streaming reduction and valid/ready
module fp_minmax_pipe
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = 1 + EXP_W + MAN_W
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            En,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] frs1,
  input  logic [XLEN-1:0] frs2,
  input  logic            Funct,
  input  logic            Reduce,
  input  logic            Last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] OUT_MIN_MAX,
  output logic            NV
);
  logic            s1_valid_q, s1_valid_d, s1_funct_q, s1_funct_d;
  logic            s1_reduce_q, s1_reduce_d, s1_last_q, s1_last_d;
  logic [XLEN-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  fp_class_t       s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
  logic            out_valid_q, out_valid_d, nv_q, nv_d;
  logic [XLEN-1:0] out_q, out_d, acc_q, acc_d;
  logic            acc_nv_q, acc_nv_d, acc_live_q, acc_live_d;
  logic            adv, emit, core_nv, acc_nv_next;
  logic [XLEN-1:0] b_mux, res;
  fp_class_t       acc_cls, b_cls;
  assign adv         = ~out_valid_q | out_ready;
  assign in_ready    = rst_n & En & adv;
  assign out_valid   = out_valid_q;
  assign OUT_MIN_MAX = out_q;
  assign NV          = nv_q;
  assign acc_cls     = fp_classify(fpw_t'(acc_q), EXP_W, MAN_W);
  // A fresh burst compares the element with itself: yields the element, or canonical NaN if NaN
  assign b_mux = s1_reduce_q ? (acc_live_q ? acc_q : s1_a_q) : s1_b_q;
  assign b_cls = s1_reduce_q ? (acc_live_q ? acc_cls : s1_cls_a_q) : s1_cls_b_q;
  assign emit        = s1_valid_q & (~s1_reduce_q | s1_last_q);
  assign acc_nv_next = (acc_live_q & acc_nv_q) | core_nv;
  fp_cmp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W), .XLEN(XLEN)) u_core (
    .a_i(s1_a_q), .b_i(b_mux), .a_cls_i(s1_cls_a_q), .b_cls_i(b_cls),
    .funct_i(s1_funct_q), .res_o(res), .nv_o(core_nv)
  );
  // Next state: both stages move together on adv; En low flushes valids and the accumulator
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_funct_d  = s1_funct_q;
    s1_reduce_d = s1_reduce_q;
    s1_last_d   = s1_last_q;
    s1_cls_a_d  = s1_cls_a_q;
    s1_cls_b_d  = s1_cls_b_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    nv_d        = nv_q;
    acc_d       = acc_q;
    acc_nv_d    = acc_nv_q;
    acc_live_d  = acc_live_q;
    if (!En) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      acc_live_d  = 1'b0;
    end else if (adv) begin
      s1_valid_d  = in_valid;
      s1_a_d      = frs1;
      s1_b_d      = frs2;
      s1_funct_d  = Funct;
      s1_reduce_d = Reduce;
      s1_last_d   = Last;
      s1_cls_a_d  = fp_classify(fpw_t'(frs1), EXP_W, MAN_W);
      s1_cls_b_d  = fp_classify(fpw_t'(frs2), EXP_W, MAN_W);
      out_valid_d = emit;
      if (emit) begin
        out_d = res;
        nv_d  = s1_reduce_q ? acc_nv_next : core_nv;
      end
      if (s1_valid_q & s1_reduce_q) begin
        acc_d      = res;
        acc_nv_d   = acc_nv_next;
        acc_live_d = ~s1_last_q;
      end
    end
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_funct_q  <= 1'b0;
      s1_reduce_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_cls_a_q  <= '0;
      s1_cls_b_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      nv_q        <= 1'b0;
      acc_q       <= '0;
      acc_nv_q    <= 1'b0;
      acc_live_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_funct_q  <= s1_funct_d;
      s1_reduce_q <= s1_reduce_d;
      s1_last_q   <= s1_last_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      nv_q        <= nv_d;
      acc_q       <= acc_d;
      acc_nv_q    <= acc_nv_d;
      acc_live_q  <= acc_live_d;
    end
  end
endmodule

// File: tb/tb_fp_minmax_pipe.sv
// tb_fp_minmax_pipe: directed self-checking bench for fp_minmax_pipe
module tb_fp_minmax_pipe;
  logic        CLK = 0, rst_n = 0, En = 1, in_valid = 0, Funct = 0, Reduce = 0, Last = 0, out_ready = 1;
  logic [31:0] frs1 = 0, frs2 = 0;
  logic        in_ready, out_valid, NV;
  logic [31:0] OUT_MIN_MAX;
  int          errors = 0, checks = 0;
  typedef struct {
    logic [31:0] a, b;
    logic f, r, l;
  } beat_t;
  beat_t       seq[$];
  logic [31:0] got_v[$];
  logic        got_nv[$];
  int          got_at;

  fp_minmax_pipe dut (
    .CLK(CLK), .rst_n(rst_n), .En(En), .in_valid(in_valid), .in_ready(in_ready),
    .frs1(frs1), .frs2(frs2), .Funct(Funct), .Reduce(Reduce), .Last(Last),
    .out_valid(out_valid), .out_ready(out_ready), .OUT_MIN_MAX(OUT_MIN_MAX), .NV(NV)
  );

  always #5 CLK = ~CLK;

  function automatic beat_t mk(logic [31:0] a, logic [31:0] b, logic f, logic r, logic l);
    beat_t t;
    t.a = a; t.b = b; t.f = f; t.r = r; t.l = l;
    return t;
  endfunction

  // Plays seq one beat per cycle with out_ready high, then idles; collects every output
  task automatic run_seq;
    got_v.delete();
    got_nv.delete();
    got_at = -1;
    for (int i = 0; i < seq.size() + 6; i++) begin
      @(posedge CLK); #1;
      if (out_valid) begin
        got_v.push_back(OUT_MIN_MAX);
        got_nv.push_back(NV);
        if (got_at < 0) got_at = i;
      end
      if (i < seq.size()) begin
        in_valid = 1; frs1 = seq[i].a; frs2 = seq[i].b;
        Funct = seq[i].f; Reduce = seq[i].r; Last = seq[i].l;
      end else begin
        in_valid = 0; Reduce = 0; Last = 0;
      end
    end
    seq.delete();
  endtask

  task automatic test_reset;
    #1;
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (OUT_MIN_MAX !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 00000000", OUT_MIN_MAX); end
    if (NV !== 1'b0) begin errors++; $display("FAIL reset_nv: got %b want 0", NV); end
    @(posedge CLK); @(posedge CLK); #1;
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pairwise;
    logic [31:0] va[10] = '{32'h3F800000, 32'h80000000, 32'h80000000, 32'h7FC00000, 32'h7F800001,
                            32'h7FC00000, 32'h00000001, 32'h80000001, 32'hFFC00001, 32'h3F800000};
    logic [31:0] vb[10] = '{32'h40000000, 32'h00000000, 32'h00000000, 32'hC0400000, 32'h3F800000,
                            32'h7F800001, 32'h00800000, 32'h80000002, 32'h7FC00005, 32'h7F800000};
    logic        vf[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ve[10] = '{32'h3F800000, 32'h00000000, 32'h80000000, 32'hC0400000, 32'h3F800000,
                            32'h7FC00000, 32'h00000001, 32'h80000001, 32'h7FC00000, 32'h7F800000};
    logic        vn[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      seq.push_back(mk(va[k], vb[k], vf[k], 1'b0, 1'b0));
      run_seq();
      checks += 2;
      if (got_v.size() != 1) begin
        errors++; $display("FAIL pair%0d_count: got %0d want 1", k, got_v.size());
      end else begin
        checks += 2;
        if (got_v[0] !== ve[k]) begin errors++; $display("FAIL pair%0d_value: got %h want %h", k, got_v[0], ve[k]); end
        if (got_nv[0] !== vn[k]) begin errors++; $display("FAIL pair%0d_nv: got %b want %b", k, got_nv[0], vn[k]); end
      end
      if (got_at != 2) begin errors++; $display("FAIL pair%0d_latency: got %0d want 2", k, got_at); end
    end
  endtask

  task automatic test_reduce;
    logic [31:0] ve[5] = '{32'h40F00000, 32'hBF800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
    logic        vn[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int          va[5] = '{5, 4, 3, 2, 3};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin
          seq.push_back(mk(32'h3F800000, 0, 1, 1, 0)); seq.push_back(mk(32'hC0A00000, 0, 1, 1, 0));
          seq.push_back(mk(32'h40F00000, 0, 1, 1, 0)); seq.push_back(mk(32'h40000000, 0, 1, 1, 1));
        end
        1: begin
          seq.push_back(mk(32'h7F800001, 0, 0, 1, 0)); seq.push_back(mk(32'h40400000, 0, 0, 1, 0));
          seq.push_back(mk(32'hBF800000, 0, 0, 1, 1));
        end
        2: begin
          seq.push_back(mk(32'h7FC00000, 0, 1, 1, 0)); seq.push_back(mk(32'h7F800002, 0, 1, 1, 1));
        end
        3: seq.push_back(mk(32'hFFC00000, 0, 0, 1, 1));
        default: begin
          seq.push_back(mk(32'h80000000, 0, 0, 1, 0)); seq.push_back(mk(32'h00000000, 0, 0, 1, 1));
        end
      endcase
      run_seq();
      checks += 2;
      if (got_v.size() != 1) begin
        errors++; $display("FAIL reduce%0d_count: got %0d want 1", k, got_v.size());
      end else begin
        checks += 2;
        if (got_v[0] !== ve[k]) begin errors++; $display("FAIL reduce%0d_value: got %h want %h", k, got_v[0], ve[k]); end
        if (got_nv[0] !== vn[k]) begin errors++; $display("FAIL reduce%0d_nv: got %b want %b", k, got_nv[0], vn[k]); end
      end
      if (got_at != va[k]) begin errors++; $display("FAIL reduce%0d_latency: got %0d want %0d", k, got_at, va[k]); end
    end
  endtask

  task automatic test_mixed;
    seq.push_back(mk(32'h40000000, 0, 1, 1, 0));
    seq.push_back(mk(32'hC0000000, 32'h41000000, 1, 0, 0));
    seq.push_back(mk(32'h3F800000, 0, 1, 1, 1));
    run_seq();
    checks++;
    if (got_v.size() != 2) begin
      errors++; $display("FAIL mixed_count: got %0d want 2", got_v.size());
    end else begin
      checks += 2;
      if (got_v[0] !== 32'h41000000) begin errors++; $display("FAIL mixed_pair: got %h want 41000000", got_v[0]); end
      if (got_v[1] !== 32'h40000000) begin errors++; $display("FAIL mixed_burst: got %h want 40000000", got_v[1]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a[4] = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h00000000};
    logic [31:0] b[4] = '{32'h40000000, 32'h40800000, 32'hBF800000, 32'h80000000};
    logic        f[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e[4] = '{32'h40000000, 32'h40400000, 32'hBF800000, 32'h80000000};
    logic [31:0] got[$];
    logic [31:0] hold = 0;
    int          idx = 0, stall = 0;
    bit          seen = 0, acc_x, out_x;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      acc_x = in_valid & in_ready;
      out_x = out_valid & out_ready;
      if (out_x) got.push_back(OUT_MIN_MAX);
      @(posedge CLK); #1;
      if (acc_x) idx++;
      if (out_valid && !seen) begin seen = 1; stall = 3; hold = OUT_MIN_MAX; end
      if (stall > 0) begin
        out_ready = 0; stall--;
        #1;
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        if (OUT_MIN_MAX !== hold) begin errors++; $display("FAIL stall_hold: got %h want %h", OUT_MIN_MAX, hold); end
        if (OUT_MIN_MAX !== e[0]) begin errors++; $display("FAIL stall_value: got %h want %h", OUT_MIN_MAX, e[0]); end
      end else out_ready = 1;
      in_valid = idx < 4;
      if (idx < 4) begin frs1 = a[idx]; frs2 = b[idx]; Funct = f[idx]; Reduce = 0; Last = 0; end
    end
    in_valid = 0; out_ready = 1;
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== e[k]) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", k, got[k], e[k]); end
      end
    end
  endtask

  task automatic test_abort;
    seq.push_back(mk(32'h42C80000, 0, 1, 1, 0)); seq.push_back(mk(32'h42000000, 0, 1, 1, 0));
    run_seq();
    checks++;
    if (got_v.size() != 0) begin errors++; $display("FAIL abort_rst_no_out: got %0d want 0", got_v.size()); end
    @(posedge CLK); #1;
    rst_n = 0;
    #1;
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_rst_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_rst_out_valid: got %b want 0", out_valid); end
    if (OUT_MIN_MAX !== 32'h0) begin errors++; $display("FAIL abort_rst_out: got %h want 00000000", OUT_MIN_MAX); end
    @(posedge CLK); #1;
    rst_n = 1;
    seq.push_back(mk(32'h41200000, 0, 1, 1, 1));
    run_seq();
    checks++;
    if (got_v.size() != 1 || got_v[0] !== 32'h41200000) begin
      errors++; $display("FAIL abort_rst_result: got %h (n=%0d) want 41200000", got_v.size() ? got_v[0] : 32'hx, got_v.size());
    end
    seq.push_back(mk(32'h42C80000, 0, 1, 1, 0)); seq.push_back(mk(32'h42000000, 0, 1, 1, 0));
    run_seq();
    @(posedge CLK); #1;
    En = 0;
    #1;
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_en_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_en_out_valid: got %b want 0", out_valid); end
    if (OUT_MIN_MAX !== 32'h41200000) begin errors++; $display("FAIL abort_en_hold: got %h want 41200000", OUT_MIN_MAX); end
    @(posedge CLK); #1;
    En = 1;
    seq.push_back(mk(32'h40A00000, 0, 1, 1, 1));
    run_seq();
    checks++;
    if (got_v.size() != 1 || got_v[0] !== 32'h40A00000) begin
      errors++; $display("FAIL abort_en_result: got %h (n=%0d) want 40A00000", got_v.size() ? got_v[0] : 32'hx, got_v.size());
    end
  endtask

  initial begin
    test_reset();
    test_pairwise();
    test_reduce();
    test_mixed();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
